// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, NUM_RD comb reads, two prioritised writes, hardwired r0.
// Ports: i_clk, i_rst_n, i_raddr/o_rdata, i_we*/i_waddr*/i_wdata*, i_clr, o_ready, o_wcoll. Option: REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  input  logic                     i_we0,
  input  logic [ADDR_W-1:0]        i_waddr0,
  input  logic [DATA_W-1:0]        i_wdata0,
  input  logic                     i_we1,
  input  logic [ADDR_W-1:0]        i_waddr1,
  input  logic [DATA_W-1:0]        i_wdata1,
  input  logic                     i_clr,
  output logic                     o_ready,
  output logic                     o_wcoll
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nx;
  logic              rdy;
  logic              wr_ok;
  logic              coll_nx;

  logic [DATA_W-1:0] mem [DEPTH];

  assign rdy   = (state == READY);
  assign wr_ok = rdy && !i_clr;

  assign coll_nx = i_we0 && i_we1 &&
                   (i_waddr0 == i_waddr1) &&
                   (i_waddr0 != '0) && wr_ok;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= CLEAR;
      cnt     <= '0;
      o_wcoll <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      o_wcoll <= coll_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      CLEAR: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == LAST) begin
          state_nx = READY;
          cnt_nx   = '0;
        end
      end
      READY: begin
        if (i_clr) begin
          state_nx = CLEAR;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  assign o_ready = rdy;

  // The array has no reset; the sweep zeroes it one entry per edge.
  // Port 1 is written last so it wins on a shared address.
  always_ff @(posedge i_clk) begin
    if (!rdy) begin
      mem[cnt] <= '0;
    end else if (!i_clr) begin
      if (i_we0 && i_waddr0 != '0)
        mem[i_waddr0] <= i_wdata0;
      if (i_we1 && i_waddr1 != '0)
        mem[i_waddr1] <= i_wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = i_raddr[k*ADDR_W +: ADDR_W];

    always_comb begin
      rd = '0;
      if (rdy && ra != '0) begin
        rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
        if (!i_clr) begin
          if (i_we1 && i_waddr1 == ra)
            rd = i_wdata1;
          else if (i_we0 && i_waddr0 == ra)
            rd = i_wdata0;
        end
`endif
      end
    end

    assign o_rdata[k*DATA_W +: DATA_W] = rd;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized self-checking bench for regfile_mp.
// Compares against an array model of the register file and its clear sweep.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic           clk;
  logic           rst_n;
  logic [NR*AW-1:0] raddr;
  logic [NR*DW-1:0] rdata;
  logic           we0, we1;
  logic [AW-1:0]  wa0, wa1;
  logic [DW-1:0]  wd0, wd1;
  logic           clr;
  logic           ready;
  logic           wcoll;

  int total;
  int bad;

  logic [DW-1:0] ref_mem [DEPTH];
  int            sweep;
  logic          ecoll;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_raddr (raddr),
    .o_rdata (rdata),
    .i_we0   (we0),
    .i_waddr0(wa0),
    .i_wdata0(wd0),
    .i_we1   (we1),
    .i_waddr1(wa1),
    .i_wdata1(wd1),
    .i_clr   (clr),
    .o_ready (ready),
    .o_wcoll (wcoll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    sweep = DEPTH;
    ecoll = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      ecoll = 1'b0;
      if (sweep > 0) begin
        sweep--;
      end else if (clr) begin
        model_reset();
      end else begin
        ecoll = we0 && we1 && wa0 == wa1 && wa0 != 0;
        if (we0 && wa0 != 0) ref_mem[wa0] = wd0;
        if (we1 && wa1 != 0) ref_mem[wa1] = wd1;
      end
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (sweep > 0 || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!clr) begin
      if (we1 && wa1 == a) return wd1;
      if (we0 && wa0 == a) return wd0;
    end
`endif
    return ref_mem[a];
  endfunction

  task automatic idle();
    we0 = 0; we1 = 0; clr = 0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_a();
    return AW'($urandom_range(0, DEPTH - 1));
  endfunction

  task automatic test_reset();
    logic [AW-1:0] a;
    idle();
    raddr = '0;
    rst_n = 0;
    model_reset();
    repeat (3) cyc();
    total++;
    if (ready !== 1'b0 || wcoll !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags ready=%b wcoll=%b want 0/0", ready, wcoll);
    end
    rst_n = 1;
    for (int i = 1; i <= DEPTH; i++) begin
      raddr = {rnd_a(), rnd_a()};
      #1;
      for (int k = 0; k < NR; k++) begin
        total++;
        if (rdata[k*DW +: DW] !== '0) begin
          bad++;
          $display("FAIL reset_rd%0d edge=%0d got=%h want=0",
                   k, i, rdata[k*DW +: DW]);
        end
      end
      cyc();
      total++;
      if (ready !== (i == DEPTH)) begin
        bad++;
        $display("FAIL reset_ready edge=%0d got=%b want=%b",
                 i, ready, i == DEPTH);
      end
    end
    a = 0;
  endtask

  task automatic test_basic();
    idle();
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF;
    cyc();
    idle();
    raddr = {5'd5, 5'd5};
    #1;
    for (int k = 0; k < NR; k++) begin
      total++;
      if (rdata[k*DW +: DW] !== 32'hDEADBEEF) begin
        bad++;
        $display("FAIL basic_r5_p%0d got=%h want=deadbeef",
                 k, rdata[k*DW +: DW]);
      end
    end
    we0 = 1; wa0 = 0; wd0 = 32'h1234;
    cyc();
    idle();
    raddr = {5'd0, 5'd0};
    #1;
    total++;
    if (rdata !== '0) begin
      bad++;
      $display("FAIL basic_r0 got=%h want=0", rdata);
    end
  endtask

  task automatic test_collision();
    idle();
    we0 = 1; wa0 = 7; wd0 = 32'hAAAA;
    we1 = 1; wa1 = 7; wd1 = 32'h5555;
    cyc();
    total++;
    if (wcoll !== 1'b1) begin
      bad++;
      $display("FAIL coll_flag got=%b want=1", wcoll);
    end
    idle();
    raddr = {5'd0, 5'd7};
    #1;
    total++;
    if (rdata[DW-1:0] !== 32'h5555) begin
      bad++;
      $display("FAIL coll_data got=%h want=5555", rdata[DW-1:0]);
    end
    cyc();
    total++;
    if (wcoll !== 1'b0) begin
      bad++;
      $display("FAIL coll_pulse got=%b want=0", wcoll);
    end
    we0 = 1; wa0 = 0; wd0 = 32'hAAAA;
    we1 = 1; wa1 = 0; wd1 = 32'h5555;
    cyc();
    total++;
    if (wcoll !== 1'b0) begin
      bad++;
      $display("FAIL coll_r0 got=%b want=0", wcoll);
    end
    idle();
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    idle();
    we0 = 1; wa0 = 3; wd0 = 32'hCAFE;
    raddr = {5'd0, 5'd3};
`ifdef REGFILE_BYPASS_EN
    want = 32'hCAFE;
`else
    want = 32'h0;
`endif
    #1;
    total++;
    if (rdata[DW-1:0] !== want) begin
      bad++;
      $display("FAIL bypass_same got=%h want=%h", rdata[DW-1:0], want);
    end
    cyc();
    idle();
    #1;
    total++;
    if (rdata[DW-1:0] !== 32'hCAFE) begin
      bad++;
      $display("FAIL bypass_next got=%h want=cafe", rdata[DW-1:0]);
    end
  endtask

  task automatic test_clear();
    idle();
    for (int r = 1; r < DEPTH; r++) begin
      we0 = 1; wa0 = AW'(r); wd0 = $urandom() | 32'h1;
      cyc();
    end
    idle();
    clr = 1;
    we0 = 1; wa0 = 2; wd0 = 32'h99;
    cyc();
    idle();
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL clear_fall got=%b want=0", ready);
    end
    raddr = {5'd0, 5'd2};
    #1;
    total++;
    if (rdata[DW-1:0] !== '0) begin
      bad++;
      $display("FAIL clear_r2 got=%h want=0", rdata[DW-1:0]);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      cyc();
      total++;
      if (ready !== (i == DEPTH)) begin
        bad++;
        $display("FAIL clear_ready edge=%0d got=%b want=%b",
                 i, ready, i == DEPTH);
      end
    end
    for (int r = 1; r < DEPTH; r++) begin
      raddr = {AW'(r), AW'(DEPTH - r)};
      #1;
      total++;
      if (rdata !== '0) begin
        bad++;
        $display("FAIL clear_zero r=%0d got=%h want=0", r, rdata);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    idle();
    clr = 1;
    cyc();
    idle();
    repeat (10) cyc();
    rst_n = 0;
    model_reset();
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_async got=%b want=0", ready);
    end
    repeat (2) cyc();
    rst_n = 1;
    n = 0;
    while (n < 40 && ready !== 1'b1) begin
      cyc();
      n++;
    end
    total++;
    if (n != DEPTH) begin
      bad++;
      $display("FAIL midrst_edges got=%0d want=%0d", n, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int c = 0; c < 400; c++) begin
      we0 = 1'($urandom_range(0, 1));
      we1 = 1'($urandom_range(0, 1));
      wa0 = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3)) : rnd_a();
      wa1 = ($urandom_range(0, 2) == 0) ? wa0 : rnd_a();
      wd0 = $urandom();
      wd1 = $urandom();
      clr = ($urandom_range(0, 59) == 0);
      raddr[AW-1:0] = ($urandom_range(0, 2) == 0) ? wa0 : rnd_a();
      raddr[2*AW-1:AW] = ($urandom_range(0, 2) == 0) ? wa1 : rnd_a();
      #1;
      for (int k = 0; k < NR; k++) begin
        a = raddr[k*AW +: AW];
        total++;
        if (rdata[k*DW +: DW] !== exp_rd(a)) begin
          bad++;
          $display("FAIL rnd_rd%0d cyc=%0d a=%0d got=%h want=%h",
                   k, c, a, rdata[k*DW +: DW], exp_rd(a));
        end
      end
      cyc();
      total++;
      if (ready !== (sweep == 0) || wcoll !== ecoll) begin
        bad++;
        $display("FAIL rnd_flags cyc=%0d ready=%b/%b wcoll=%b/%b",
                 c, ready, sweep == 0, wcoll, ecoll);
      end
    end
    idle();
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 0;
    raddr = '0;
    idle();
    model_reset();
    test_reset();
    test_basic();
    test_collision();
    test_bypass();
    test_clear();
    test_reset_mid_sweep();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
